// File: rtl/stepper_pkg.sv
// Shared types for the step pulse generator and the Motor_* top-level mux.
// Phase encoding is visible on LEDs/display, so its values must stay stable.
package stepper_pkg;

  typedef enum logic [1:0] {
    RP_IDLE   = 2'd0,
    RP_ACCEL  = 2'd1,
    RP_CRUISE = 2'd2,
    RP_DECEL  = 2'd3
  } ramp_phase_e;

  typedef enum logic [1:0] {
    SF_IDLE   = 2'd0,
    SF_RUN    = 2'd1,
    SF_FINISH = 2'd2
  } step_fsm_e;

endpackage

// File: rtl/step_interval_timer.sv
// Loadable down-counter that times the gap between steps.
// tick_o is high while the count sits at zero; a load on that cycle restarts it.
module step_interval_timer #(
  parameter int unsigned PERIOD_W = 24
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic [PERIOD_W-1:0] load_val_i,
  input  logic                en_i,
  output logic                tick_o
);

  logic [PERIOD_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - PERIOD_W'(1);
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/step_ramp_generator.sv
// Move sequencer: turns a (steps, dir) command into rotate_pulse toggles whose
// spacing follows a trapezoidal/triangular accel-cruise-decel period profile.
module step_ramp_generator
  import stepper_pkg::*;
#(
  parameter int unsigned COUNT_W      = 16,
  parameter int unsigned PERIOD_W     = 24,
  parameter int unsigned START_PERIOD = 135000,
  parameter int unsigned MIN_PERIOD   = 27000,
  parameter int unsigned ACCEL_DEC    = 2700
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [COUNT_W-1:0] cmd_steps_i,
  input  logic               cmd_dir_i,
  input  logic               abort_i,
  output logic               rotate_pulse_o,
  output logic               direction_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [COUNT_W-1:0] steps_left_o,
  output logic [1:0]         ramp_phase_o
);

  localparam logic [PERIOD_W:0]   START_X    = (PERIOD_W+1)'(START_PERIOD);
  localparam logic [PERIOD_W:0]   MIN_X      = (PERIOD_W+1)'(MIN_PERIOD);
  localparam logic [PERIOD_W:0]   DEC_X      = (PERIOD_W+1)'(ACCEL_DEC);
  localparam logic [PERIOD_W-1:0] START_P    = PERIOD_W'(START_PERIOD);
  localparam logic [PERIOD_W-1:0] START_LOAD = PERIOD_W'(START_PERIOD - 1);

  step_fsm_e           state_q;
  ramp_phase_e         phase_q;
  logic [PERIOD_W-1:0] period_q;
  logic [COUNT_W-1:0]  steps_left_q;
  logic [COUNT_W-1:0]  ramp_cnt_q;
  logic                rotate_q;
  logic                dir_q;
  logic                busy_q;
  logic                done_q;
  logic                ready_q;

  logic                run;
  logic                accept;
  logic                tick;
  logic                step;
  logic [PERIOD_W:0]   period_up;
  logic [PERIOD_W:0]   period_dn;
  logic [PERIOD_W-1:0] period_d;
  logic [COUNT_W-1:0]  ramp_cnt_d;
  logic [COUNT_W-1:0]  steps_stepped;
  logic [COUNT_W-1:0]  steps_left_d;
  ramp_phase_e         phase_d;
  logic                timer_load;
  logic [PERIOD_W-1:0] timer_val;

  assign run       = (state_q == SF_RUN);
  assign accept    = cmd_valid_i & ready_q;
  assign step      = run & tick;
  assign period_up = {1'b0, period_q} + DEC_X;
  assign period_dn = {1'b0, period_q} - DEC_X;

  // Profile update for this cycle: the step (if any) first, then the abort clamp
  // applied to the post-step counts.
  always_comb begin
    steps_stepped = steps_left_q;
    ramp_cnt_d    = ramp_cnt_q;
    period_d      = period_q;
    phase_d       = phase_q;
    if (step) begin
      steps_stepped = steps_left_q - COUNT_W'(1);
      if (steps_stepped == '0) begin
        phase_d = RP_IDLE;
      end else if (steps_stepped <= ramp_cnt_q) begin
        period_d   = (period_up > START_X) ? START_P : period_up[PERIOD_W-1:0];
        ramp_cnt_d = (ramp_cnt_q == '0) ? '0 : ramp_cnt_q - COUNT_W'(1);
        phase_d    = RP_DECEL;
      end else if ({1'b0, period_q} > MIN_X) begin
        // Compare before subtracting so a small period can never wrap.
        period_d   = ({1'b0, period_q} >= (MIN_X + DEC_X)) ? period_dn[PERIOD_W-1:0]
                                                           : MIN_X[PERIOD_W-1:0];
        ramp_cnt_d = ramp_cnt_q + COUNT_W'(1);
        phase_d    = RP_ACCEL;
      end else begin
        phase_d = RP_CRUISE;
      end
    end
    steps_left_d = steps_stepped;
    if (run && abort_i && (ramp_cnt_d < steps_stepped)) begin
      steps_left_d = ramp_cnt_d;
    end
  end

  assign timer_load = accept | step;
  assign timer_val  = accept ? START_LOAD : (period_d - PERIOD_W'(1));

  step_interval_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .en_i       (run),
    .tick_o     (tick)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= SF_IDLE;
      phase_q      <= RP_IDLE;
      period_q     <= START_P;
      steps_left_q <= '0;
      ramp_cnt_q   <= '0;
      rotate_q     <= 1'b0;
      dir_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        SF_IDLE: begin
          if (accept) begin
            dir_q        <= cmd_dir_i;
            steps_left_q <= cmd_steps_i;
            period_q     <= START_P;
            ramp_cnt_q   <= '0;
            ready_q      <= 1'b0;
            if (cmd_steps_i == '0) begin
              state_q <= SF_FINISH;
            end else begin
              state_q <= SF_RUN;
              busy_q  <= 1'b1;
              phase_q <= RP_ACCEL;
            end
          end
        end
        SF_RUN: begin
          if (step) begin
            rotate_q <= ~rotate_q;
          end
          steps_left_q <= steps_left_d;
          ramp_cnt_q   <= ramp_cnt_d;
          period_q     <= period_d;
          phase_q      <= phase_d;
          if (steps_left_d == '0) begin
            state_q <= SF_FINISH;
            busy_q  <= 1'b0;
            phase_q <= RP_IDLE;
          end
        end
        SF_FINISH: begin
          state_q <= SF_IDLE;
          done_q  <= 1'b1;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= SF_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o    = ready_q;
  assign rotate_pulse_o = rotate_q;
  assign direction_o    = dir_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign steps_left_o   = steps_left_q;
  assign ramp_phase_o   = phase_q;

endmodule

// File: tb/tb_step_ramp_generator.sv
// Directed bench for step_ramp_generator with START_PERIOD=20, MIN_PERIOD=8, ACCEL_DEC=4.
// Toggle times are counted in clock edges after the accepting edge.
module tb_step_ramp_generator;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_steps;
  logic        cmd_dir;
  logic        abort;
  logic        rotate_pulse;
  logic        direction;
  logic        busy;
  logic        done;
  logic [15:0] steps_left;
  logic [1:0]  ramp_phase;

  int vectors = 0;
  int miscompares = 0;

  int tog[32];
  int ph[32];
  int slt[32];
  int ntog;
  int done_cnt;
  int done_n;
  int busy_seen;
  int sl_abort;

  step_ramp_generator #(
    .COUNT_W      (16),
    .PERIOD_W     (24),
    .START_PERIOD (20),
    .MIN_PERIOD   (8),
    .ACCEL_DEC    (4)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_steps_i    (cmd_steps),
    .cmd_dir_i      (cmd_dir),
    .abort_i        (abort),
    .rotate_pulse_o (rotate_pulse),
    .direction_o    (direction),
    .busy_o         (busy),
    .done_o         (done),
    .steps_left_o   (steps_left),
    .ramp_phase_o   (ramp_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic issue(input int steps, input logic dir);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_steps = 16'(steps);
    cmd_dir   = dir;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Observe a move: record toggle times/phase/steps_left, done strobes, busy.
  // abort_after: raise abort for one cycle right after that toggle (0 = never).
  // intrude_at: hold a competing command on cmd_valid for 3 cycles from that cycle.
  task automatic watch(input int max_cyc, input int abort_after, input int intrude_at);
    logic prev;
    int   post_done;
    ntog = 0; done_cnt = 0; done_n = -1; busy_seen = 0; sl_abort = -1; post_done = 0;
    for (int i = 0; i < 32; i++) begin
      tog[i] = -1; ph[i] = -1; slt[i] = -1;
    end
    prev = rotate_pulse;
    for (int n = 1; n <= max_cyc; n++) begin
      @(negedge clk);
      if (abort) sl_abort = int'(steps_left);
      abort = 1'b0;
      if (intrude_at != 0 && n == intrude_at) begin
        cmd_valid = 1'b1; cmd_steps = 16'd7; cmd_dir = 1'b1;
      end
      if (intrude_at != 0 && n == intrude_at + 3) cmd_valid = 1'b0;
      if (rotate_pulse !== prev) begin
        if (ntog < 32) begin
          tog[ntog] = n; ph[ntog] = int'(ramp_phase); slt[ntog] = int'(steps_left);
        end
        ntog++;
        prev = rotate_pulse;
        if (ntog == abort_after) abort = 1'b1;
      end
      if (busy === 1'b1) busy_seen = 1;
      if (done === 1'b1) begin
        done_cnt++;
        done_n = n;
      end
      if (done_n >= 0) begin
        post_done++;
        if (post_done > 4) break;
      end
    end
    abort = 1'b0;
    cmd_valid = 1'b0;
  endtask

  int exp_a_t[10] = '{20, 36, 48, 56, 64, 72, 80, 92, 108, 128};
  int exp_a_p[10] = '{1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
  int exp_b_t[4]  = '{20, 36, 48, 64};
  int exp_b_p[4]  = '{1, 1, 3, 0};
  int exp_d_t[8]  = '{20, 36, 48, 56, 64, 72, 84, 100};

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_steps = '0; cmd_dir = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check("por_busy", busy, 0);
    check("por_done", done, 0);
    check("por_rotate", rotate_pulse, 0);
    check("por_steps_left", steps_left, 0);
    check("por_phase", ramp_phase, 0);
    check("por_ready", cmd_ready, 1);
    check("por_dir", direction, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full trapezoid, 10 steps, direction 1
    issue(10, 1'b1);
    check("a_busy", busy, 1);
    check("a_ready", cmd_ready, 0);
    check("a_dir", direction, 1);
    check("a_steps_left", steps_left, 10);
    watch(300, 0, 0);
    check("a_ntog", ntog, 10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("a_tog%0d", i), tog[i], exp_a_t[i]);
      check($sformatf("a_phase%0d", i), ph[i], exp_a_p[i]);
      check($sformatf("a_sl%0d", i), slt[i], 9 - i);
    end
    check("a_done_cnt", done_cnt, 1);
    check("a_done_n", done_n, 129);
    check("a_busy_end", busy, 0);
    check("a_ready_end", cmd_ready, 1);

    // Triangle, 4 steps, direction 0
    issue(4, 1'b0);
    check("b_dir", direction, 0);
    watch(200, 0, 0);
    check("b_ntog", ntog, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b_tog%0d", i), tog[i], exp_b_t[i]);
      check($sformatf("b_phase%0d", i), ph[i], exp_b_p[i]);
    end
    check("b_done_cnt", done_cnt, 1);
    check("b_done_n", done_n, 65);

    // Zero-step move
    issue(0, 1'b0);
    check("c_ready", cmd_ready, 0);
    check("c_busy", busy, 0);
    watch(20, 0, 0);
    check("c_ntog", ntog, 0);
    check("c_done_cnt", done_cnt, 1);
    check("c_done_n", done_n, 1);
    check("c_busy_seen", busy_seen, 0);

    // Abort during cruise: ramp_cnt=3 clamps steps_left to 3
    issue(10, 1'b1);
    watch(300, 5, 0);
    check("d_ntog", ntog, 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("d_tog%0d", i), tog[i], exp_d_t[i]);
    end
    check("d_sl_abort", sl_abort, 3);
    check("d_phase5", ph[5], 3);
    check("d_done_n", done_n, 101);
    check("d_steps_left", steps_left, 0);

    // Abort right after the first step, plus a competing command while busy
    issue(10, 1'b0);
    watch(300, 1, 22);
    check("e_ntog", ntog, 2);
    check("e_tog1", tog[1], 36);
    check("e_sl_abort", sl_abort, 1);
    check("e_done_cnt", done_cnt, 1);
    check("e_done_n", done_n, 37);
    check("e_dir", direction, 0);
    watch(30, 0, 0);
    check("e_no_queue_tog", ntog, 0);
    check("e_no_queue_busy", busy_seen, 0);

    // Abort while idle has no effect
    abort = 1'b1;
    repeat (3) @(negedge clk);
    abort = 1'b0;
    check("idle_abort_busy", busy, 0);
    check("idle_abort_ready", cmd_ready, 1);
    check("idle_abort_done", done, 0);

    // Reset in the middle of a move
    issue(10, 1'b1);
    repeat (30) @(negedge clk);
    check("f_pre_rotate", rotate_pulse, 1);
    check("f_pre_sl", steps_left, 9);
    rst_n = 1'b0;
    @(negedge clk);
    check("f_busy", busy, 0);
    check("f_rotate", rotate_pulse, 0);
    check("f_steps_left", steps_left, 0);
    check("f_ready", cmd_ready, 1);
    check("f_phase", ramp_phase, 0);
    check("f_dir", direction, 0);
    rst_n = 1'b1;
    @(negedge clk);
    issue(2, 1'b0);
    watch(100, 0, 0);
    check("g_ntog", ntog, 2);
    check("g_tog0", tog[0], 20);
    check("g_tog1", tog[1], 36);
    check("g_phase0", ph[0], 1);
    check("g_done_n", done_n, 37);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
